fft_result_unloader: RTL and testbench
======================================

Name: fft_result_unloader

Overview:
- Reader-side counterpart to the FFT core. After the core asserts fft_done, this block reads the N_POINTS complex results out of the result memory bank and presents them as a valid/ready stream to downstream logic, such as a UART/DMA bridge or a capture bench.
- It owns the memory read port during unload.
- It hides the memory read latency using a credit-limited skid FIFO, so downstream back-pressure never loses a word.

Parameters:
- N_POINTS, 32: number of complex results to unload; power of two.
- ADDR_W, 5: address width; log2(N_POINTS).
- DATA_W, 64: word width; [DATA_W-1:DATA_W/2] is the real part, [DATA_W/2-1:0] is the imaginary part.
- RD_LATENCY, 1: memory read latency in cycles from rd_en/rd_addr to rd_data; range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins an unload. Ignored unless state is IDLE.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  DATA_W  memory read data; valid exactly RD_LATENCY cycles after rd_en.
- out_data  out  DATA_W  streamed result word.
- out_index  out  ADDR_W  frequency bin index of out_data.
- out_valid  out  1  out_data, out_index and out_last are valid.
- out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
- out_last  out  1  high with the word whose out_index = N_POINTS-1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset, asynchronous: all of the following clear immediately and hold while rst = 1:
  - state = IDLE.
  - rd_en = 0, rd_addr = 0.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0.
  - busy = 0, done = 0.
  - Read-pipeline valid shift register, FIFO pointers and FIFO count.
- Reset mid-unload: in-flight read data is discarded; no stream word is produced after reset.
- FSM states are IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on start. Issue counter clears to 0 and busy rises the next cycle.
  - READ: assert rd_en with rd_addr = issue counter only while (outstanding reads + FIFO count) < RD_LATENCY+1; increment the counter on each issue. READ -> DRAIN in the cycle the read for address N_POINTS-1 issues.
  - DRAIN: no reads are issued. DRAIN -> DONE when the word with out_last is accepted.
  - DONE: done = 1 for one cycle, busy = 0, then -> IDLE.
- Read pipeline: a RD_LATENCY-deep shift register carries {valid, index}. When it emerges, rd_data and its index are written into the FIFO (depth RD_LATENCY+1). The credit rule guarantees the FIFO never overflows.
- Output: the FIFO head drives out_data/out_index/out_last; out_valid = FIFO not empty (first-word-fall-through).
  - Pop on out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, out_data/out_index/out_last stay stable.
- Simultaneous push and pop in one cycle: FIFO count is unchanged; ordering is preserved.
- Throughput: with out_ready held high, one word per cycle. First out_valid appears RD_LATENCY+1 cycles after the start pulse.
- Total unload with no back-pressure: start to done = N_POINTS + RD_LATENCY + 1 cycles.
- Ordering: out_index increments 0..N_POINTS-1 in natural order. rd_addr equals the index, subject to the optional feature below.
- start asserted while busy: ignored; no restart, no counter change.
- start in the same cycle as the done pulse: ignored; a new unload needs start in IDLE.
- Arithmetic: the issue counter is ADDR_W+1 bits to detect completion without wrap-around. All data passes through unmodified.

Optional Feature:
- Macro: FFT_UNLOAD_BITREV_EN.
- When defined: rd_addr = bit-reverse(issue counter) over ADDR_W bits, for cores that leave results in bit-reversed order. out_index still reports the natural bin index 0..N_POINTS-1, so the stream is always in natural order.
- When undefined: rd_addr = issue counter.
- Only the address mapping changes; timing is identical.

Test Plan:
- Memory model with RD_LATENCY = 1 and mem[i] = {i+0x100, i+0x200}; out_ready = 1; start pulse -> 32 words with out_data = mem[k] and out_index = k; first out_valid 2 cycles after start; out_last on k = 31; done 34 cycles after start.
- Back-pressure with out_ready toggling 1,0,0,1 repeating -> no word lost or duplicated; data stable while stalled; FIFO count never exceeds 2; rd_en deasserts whenever the credit limit is hit.
- RD_LATENCY = 3 with out_ready low for the first 10 cycles -> exactly 4 reads issued, then rd_en = 0 until the first pop; all 32 words then arrive in order.
- Assert rst for 1 cycle at word 12 mid-unload -> outputs clear immediately; no further out_valid; a new start performs a complete 32-word unload from index 0.
- Second start pulse while busy, and start coincident with done -> both ignored; exactly 32 words total and a single done pulse.
- With FFT_UNLOAD_BITREV_EN defined -> rd_addr sequence 0,16,8,24,4,... while out_index is 0,1,2,3,...; out_data for index 1 = mem[16].

Source files
------------

// File: rtl/fft_result_unloader.sv
// ============================================================================
// fft_result_unloader
// ----------------------------------------------------------------------------
// Reads the N_POINTS complex results out of the FFT result memory after the
// core finishes and streams them to downstream logic over valid/ready.
//
// The memory has a fixed read latency (RD_LATENCY cycles). Reads are
// credit-limited so that every issued read always has a slot in a small
// skid FIFO (depth RD_LATENCY+1). Downstream back-pressure therefore never
// drops a word. The FIFO is first-word-fall-through and also bypasses
// rd_data straight to the output when it is empty. That bypass lets the
// first word appear RD_LATENCY+1 cycles after start.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse, begins an unload (only honoured in IDLE)
//   rd_en      memory read strobe
//   rd_addr    memory read address
//   rd_data    memory read data, valid RD_LATENCY cycles after rd_en
//   out_data   streamed word ({real, imag})
//   out_index  natural frequency-bin index of out_data
//   out_valid  out_data/out_index/out_last are valid
//   out_ready  downstream accepts when out_valid && out_ready
//   out_last   marks the word with out_index = N_POINTS-1
//   busy       unload in progress
//   done       one-cycle pulse after the last word is accepted
//
// Build option:
//   FFT_UNLOAD_BITREV_EN  when defined, rd_addr is the bit-reversed issue
//                         counter, for cores that leave results in
//                         bit-reversed order. out_index always stays in
//                         natural order.
// ============================================================================
module fft_result_unloader #(
   parameter int N_POINTS   = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 64,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // ------------------------------------------------------------------------
   // Local sizing
   // ------------------------------------------------------------------------
   localparam int DEPTH = RD_LATENCY + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   // Holds outstanding reads + FIFO count. The sum is at most
   // 2*RD_LATENCY+1 (9 for RD_LATENCY = 4).
   localparam int CRD_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_W:0]   LAST_ISSUE = (ADDR_W+1)'(N_POINTS - 1);
   localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(N_POINTS - 1);
   localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(DEPTH - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]               state_q, state_d;
   logic [ADDR_W:0]          issue_cnt_q, issue_cnt_d;

   // Read pipeline: {valid, index} travels alongside the memory latency.
   logic [RD_LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
   logic [ADDR_W-1:0]        pipe_idx_q [RD_LATENCY];
   logic [ADDR_W-1:0]        pipe_idx_d [RD_LATENCY];

   // Skid FIFO
   logic [DATA_W-1:0]        fifo_data_q [DEPTH];
   logic [ADDR_W-1:0]        fifo_idx_q  [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         fifo_cnt_q, fifo_cnt_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [CRD_W-1:0]         outstanding;
   logic                     credit_ok;
   logic                     issue;
   logic [ADDR_W-1:0]        issue_idx;
   logic [ADDR_W-1:0]        addr_map;

   logic                     fifo_empty;
   logic                     in_vld;
   logic [ADDR_W-1:0]        in_idx;
   logic [DATA_W-1:0]        head_data;
   logic [ADDR_W-1:0]        head_idx;
   logic                     head_vld;
   logic                     pop;
   logic                     push;
   logic                     fifo_pop;

   assign issue_idx = issue_cnt_q[ADDR_W-1:0];

`ifdef FFT_UNLOAD_BITREV_EN
   // Results sit in bit-reversed order, so the read address is the
   // mirrored issue counter. The stream index stays natural.
   for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bitrev
      assign addr_map[gi] = issue_idx[ADDR_W-1-gi];
   end
`else
   assign addr_map = issue_idx;
`endif

   // Count reads still in flight through the memory latency.
   always_comb begin
      outstanding = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         outstanding = outstanding + {{(CRD_W-1){1'b0}}, pipe_vld_q[i]};
      end
   end

   // A read may issue only if a FIFO slot is guaranteed for its data.
   // The word on the output this cycle is still counted, even if it is
   // popped this cycle. This keeps the rule simple at the cost of one
   // cycle of slack.
   assign credit_ok = (outstanding + CRD_W'(fifo_cnt_q)) < CRD_W'(DEPTH);
   assign issue     = (state_q == ST_READ) && credit_ok;

   assign rd_en   = issue;
   assign rd_addr = issue ? addr_map : '0;

   // ------------------------------------------------------------------------
   // FIFO head / bypass
   // ------------------------------------------------------------------------
   assign in_vld     = pipe_vld_q[RD_LATENCY-1];
   assign in_idx     = pipe_idx_q[RD_LATENCY-1];
   assign fifo_empty = (fifo_cnt_q == '0);

   // When the FIFO is empty, the word emerging from memory is presented
   // directly. If it is not taken, it is pushed. The next cycle then shows
   // the same word from the FIFO, so the output stays stable while stalled.
   assign head_vld  = !fifo_empty || in_vld;
   assign head_data = fifo_empty ? rd_data : fifo_data_q[rd_ptr_q];
   assign head_idx  = fifo_empty ? in_idx  : fifo_idx_q[rd_ptr_q];

   assign out_valid = head_vld;
   assign out_data  = head_vld ? head_data : '0;
   assign out_index = head_vld ? head_idx  : '0;
   assign out_last  = head_vld && (head_idx == LAST_INDEX);

   assign pop      = head_vld && out_ready;
   assign push     = in_vld && !(fifo_empty && out_ready);
   assign fifo_pop = pop && !fifo_empty;

   assign busy = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);

   // ------------------------------------------------------------------------
   // FSM and issue counter
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_READ;
               issue_cnt_d = '0;
            end
         end
         ST_READ: begin
            if (issue) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == LAST_ISSUE) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && out_last) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Read pipeline next-state
   // ------------------------------------------------------------------------
   always_comb begin
      pipe_vld_d    = pipe_vld_q;
      pipe_idx_d    = pipe_idx_q;
      pipe_vld_d[0] = issue;
      pipe_idx_d[0] = issue_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_idx_d[i] = pipe_idx_q[i-1];
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      end
      // A push and a pop in the same cycle leave the occupancy unchanged.
      case ({push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         pipe_vld_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_idx_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         pipe_vld_q  <= pipe_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_idx_q[i] <= pipe_idx_d[i];
         end
      end
   end

   // FIFO storage needs no reset. Occupancy and pointers gate every read
   // of it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= rd_data;
         fifo_idx_q[wr_ptr_q]  <= in_idx;
      end
   end

endmodule

// File: tb/tb_fft_result_unloader.sv
// ============================================================================
// tb_fft_result_unloader
// ----------------------------------------------------------------------------
// Runs two unloaders side by side with identical stimulus: one with
// RD_LATENCY = 1 and one with RD_LATENCY = 3. Each has its own memory
// model with mem[i] = {i+0x100, i+0x200}. Expected words are queued when a
// start is accepted and checked as each word is handed off downstream.
// ============================================================================
module tb_fft_result_unloader;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic out_ready;

   logic          rd_en     [2];
   logic [AW-1:0] rd_addr   [2];
   logic [DW-1:0] rd_data   [2];
   logic [DW-1:0] out_data  [2];
   logic [AW-1:0] out_index [2];
   logic          out_valid [2];
   logic          out_last  [2];
   logic          busy      [2];
   logic          done      [2];

   always #5 clk = ~clk;

   fft_result_unloader #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
      .out_data(out_data[0]), .out_index(out_index[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready), .out_last(out_last[0]), .busy(busy[0]), .done(done[0])
   );

   fft_result_unloader #(.N_POINTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start),
      .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
      .out_data(out_data[1]), .out_index(out_index[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready), .out_last(out_last[1]), .busy(busy[1]), .done(done[1])
   );

   // ------------------------------------------------------------------------
   // Memory models and reference helpers
   // ------------------------------------------------------------------------
   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      logic [31:0] re;
      logic [31:0] im;
      re = 32'(a) + 32'h100;
      im = 32'(a) + 32'h200;
      return {re, im};
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int k);
      logic [AW-1:0] n;
      logic [AW-1:0] r;
      n = AW'(k);
`ifdef FFT_UNLOAD_BITREV_EN
      for (int b = 0; b < AW; b++) r[b] = n[AW-1-b];
`else
      r = n;
`endif
      return r;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Data is driven only in the cycle it is due. Any other cycle shows a
   // poison pattern, so a capture in the wrong cycle is visible.
   localparam logic [DW-1:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;
   logic [DW-1:0] m0_q;
   logic          m0_v;
   logic [DW-1:0] m1_q [3];
   logic          m1_v [3];

   always @(posedge clk) begin
      m0_q    <= memval(rd_addr[0]);
      m0_v    <= rd_en[0];
      m1_q[0] <= memval(rd_addr[1]);
      m1_v[0] <= rd_en[1];
      m1_q[1] <= m1_q[0];
      m1_v[1] <= m1_v[0];
      m1_q[2] <= m1_q[1];
      m1_v[2] <= m1_v[1];
   end

   assign rd_data[0] = (m0_v    === 1'b1) ? m0_q    : POISON;
   assign rd_data[1] = (m1_v[2] === 1'b1) ? m1_q[2] : POISON;

   // ------------------------------------------------------------------------
   // Check bookkeeping
   // ------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW+DW-1:0] q0 [$];
   logic [AW+DW-1:0] q1 [$];

   int            issued     [2];
   int            accepted   [2];
   int            done_cnt   [2];
   bit            seen_valid [2];
   bit            prev_stall [2];
   logic [DW-1:0] prev_data  [2];
   logic [AW+1:0] prev_ctl   [2];
   bit            chk_first;
   bit            chk_done;
   int            start_cyc;

   // ------------------------------------------------------------------------
   // Monitor: samples on the falling edge, away from the active edge
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         prev_stall[0] = 1'b0;
         prev_stall[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic [AW+DW-1:0] e;
            int               k;
            if (prev_stall[d]) begin
               check($sformatf("stall_data%0d", d), out_data[d], prev_data[d]);
               check($sformatf("stall_ctl%0d", d),
                     64'({out_valid[d], out_last[d], out_index[d]}), 64'(prev_ctl[d]));
            end
            if (rd_en[d]) begin
               check($sformatf("rd_addr%0d", d), 64'(rd_addr[d]), 64'(exp_addr(issued[d])));
               check($sformatf("credit%0d", d), 64'(issued[d] - accepted[d] <= lat_of(d)), 64'd1);
               issued[d]++;
            end
            if (out_valid[d] && chk_first && !seen_valid[d]) begin
               seen_valid[d] = 1'b1;
               check($sformatf("first_valid_lat%0d", d), 64'(cyc - start_cyc), 64'(lat_of(d) + 1));
            end
            if (out_valid[d] && out_ready) begin
               $display("dut%0d word idx=%0d data=0x%016h last=%0b cyc=%0d",
                        d, out_index[d], out_data[d], out_last[d], cyc);
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  check($sformatf("extra_word%0d", d), 64'd1, 64'd0);
               end else begin
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  k = int'(e[AW+DW-1:DW]);
                  check($sformatf("data%0d", d), out_data[d], e[DW-1:0]);
                  check($sformatf("index%0d", d), 64'(out_index[d]), 64'(e[AW+DW-1:DW]));
                  check($sformatf("last%0d", d), 64'(out_last[d]), 64'(k == N - 1));
               end
               accepted[d]++;
            end
            if (done[d]) begin
               done_cnt[d]++;
               if (chk_done) check($sformatf("done_lat%0d", d), 64'(cyc - start_cyc), 64'(N + lat_of(d) + 1));
            end
            prev_stall[d] = out_valid[d] && !out_ready;
            prev_data[d]  = out_data[d];
            prev_ctl[d]   = {out_valid[d], out_last[d], out_index[d]};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic clear_counters();
      for (int d = 0; d < 2; d++) begin
         issued[d]     = 0;
         accepted[d]   = 0;
         done_cnt[d]   = 0;
         seen_valid[d] = 1'b0;
      end
   endtask

   task automatic pulse_start(input bit accepted_exp);
      @(posedge clk); #1;
      start = 1'b1;
      if (accepted_exp) begin
         start_cyc = cyc;
         for (int k = 0; k < N; k++) begin
            q0.push_back({AW'(k), memval(exp_addr(k))});
            q1.push_back({AW'(k), memval(exp_addr(k))});
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input int bound, input bit toggle);
      bit [3:0] pat;
      bit       ok;
      pat = 4'b1001;   // out_ready sequence 1,0,0,1 (bit 3 first)
      ok  = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (done_cnt[0] >= 1 && done_cnt[1] >= 1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (toggle) out_ready = pat[3 - (i % 4)];
      end
      out_ready = 1'b1;
      check("done_reached", 64'(ok), 64'd1);
   endtask

   task automatic end_checks(input string tag);
      repeat (6) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_words%0d", tag, d), 64'(accepted[d]), 64'(N));
         check($sformatf("%s_done_pulses%0d", tag, d), 64'(done_cnt[d]), 64'd1);
         check($sformatf("%s_idle%0d", tag, d), 64'(busy[d]), 64'd0);
      end
      check({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
      check({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
   endtask

   task automatic check_cleared(input string tag);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s_valid%0d", tag, d), 64'(out_valid[d]), 64'd0);
         check($sformatf("%s_data%0d", tag, d), out_data[d], 64'd0);
         check($sformatf("%s_index%0d", tag, d), 64'(out_index[d]), 64'd0);
         check($sformatf("%s_last%0d", tag, d), 64'(out_last[d]), 64'd0);
         check($sformatf("%s_rd_en%0d", tag, d), 64'(rd_en[d]), 64'd0);
         check($sformatf("%s_rd_addr%0d", tag, d), 64'(rd_addr[d]), 64'd0);
         check($sformatf("%s_busy%0d", tag, d), 64'(busy[d]), 64'd0);
         check($sformatf("%s_done%0d", tag, d), 64'(done[d]), 64'd0);
      end
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      int s0;
      bit reached;
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      chk_first = 1'b0;
      chk_done  = 1'b0;
      clear_counters();
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      rst = 1'b0;

      // 1: plain unload, no back-pressure, latency checks
      clear_counters();
      chk_first = 1'b1;
      chk_done  = 1'b1;
      pulse_start(1'b1);
      run_until_done(200, 1'b0);
      end_checks("plain");
      chk_first = 1'b0;
      chk_done  = 1'b0;

      // 2: out_ready toggling 1,0,0,1
      clear_counters();
      pulse_start(1'b1);
      run_until_done(600, 1'b1);
      end_checks("toggle");

      // 3: out_ready low for the first 10 cycles
      clear_counters();
      chk_first = 1'b1;
      out_ready = 1'b0;
      pulse_start(1'b1);
      repeat (9) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("stalled_reads%0d", d), 64'(issued[d]), 64'(lat_of(d) + 1));
         check($sformatf("stalled_rd_en%0d", d), 64'(rd_en[d]), 64'd0);
      end
      out_ready = 1'b1;
      run_until_done(200, 1'b0);
      end_checks("stall10");
      chk_first = 1'b0;

      // 4: reset at word 12, then a fresh full unload
      clear_counters();
      pulse_start(1'b1);
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (accepted[0] >= 12) begin
            reached = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reached_word12", 64'(reached), 64'd1);
      rst = 1'b1;
      #1;
      check_cleared("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete();
      q1.delete();
      clear_counters();
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_words0", 64'(accepted[0]), 64'd0);
      check("post_rst_words1", 64'(accepted[1]), 64'd0);
      chk_first = 1'b1;
      pulse_start(1'b1);
      run_until_done(200, 1'b0);
      end_checks("rerun");
      chk_first = 1'b0;

      // 5: start while busy, and start in the same cycle as done
      clear_counters();
      pulse_start(1'b1);
      s0 = start_cyc;
      repeat (4) @(posedge clk);
      pulse_start(1'b0);
      while (cyc < s0 + N + 2) begin
         @(posedge clk); #1;
      end
      check("done_coincident", 64'(done[0]), 64'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_until_done(200, 1'b0);
      repeat (10) @(posedge clk);
      end_checks("ignored_start");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
